// File: rtl/prog_pkg.sv
// Shared definitions for the program loader: loader FSM states, the frame
// start byte, bus widths and a helper that decides whether a count byte is
// usable.
// No ports (package).
package prog_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    // Frame start byte
    localparam logic [DATA_W-1:0] HEADER = 8'hA5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        COUNT = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4,
        ERR   = 3'd5
    } state_t;

    // A count byte is usable when it lies in 1..127. Zero is rejected, and so
    // is anything with bit 7 set.
    function automatic logic count_ok(input logic [DATA_W-1:0] value);
        return (value != 8'd0) && (value[7] == 1'b0);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream plus program-memory write port of the loader.
// Ports (signals):
//   in_valid / in_data  : host byte offered to the loader
//   in_ready            : loader accepts the byte this cycle
//   inst_address/inst_data/inst_we : program-memory write port
// Modports: master = host / memory side, slave = loader side.
interface prog_loader_if import prog_pkg::*; ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] inst_address;
    logic [DATA_W-1:0] inst_data;
    logic              inst_we;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  inst_address,
        input  inst_data,
        input  inst_we
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output inst_address,
        output inst_data,
        output inst_we
    );

endinterface

// File: rtl/prog_csum.sv
// 8-bit running-sum accumulator used for the frame checksum.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero the sum (new frame)
//   add_en   : add data to the sum this cycle
//   data     : byte to add
//   sum      : current sum, modulo 256
module prog_csum import prog_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] sum_r;

    // Accumulate the payload bytes; clear has priority over add.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= 8'd0;
        end else if (clear) begin
            sum_r <= 8'd0;
        end else if (add_en) begin
            sum_r <= sum_r + data;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign sum = sum_r;

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses framed bytes from a host (HEADER, address, count,
// data bytes, checksum), writes the data bytes into program memory, and
// releases the CPU from reset once a frame's checksum matches.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : host byte stream in, program-memory write port out
//   cpu_run  : 1 = CPU released, 0 = CPU held in reset
//   busy     : a frame is being received
//   err      : sticky error from the last frame
module prog_loader import prog_pkg::*; (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus,
    output logic          cpu_run,
    output logic          busy,
    output logic          err
);

    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              in_ready_r;
    logic [ADDR_W-1:0] inst_address_r;
    logic [DATA_W-1:0] inst_data_r;
    logic              inst_we_r;
    logic              cpu_run_r;
    logic              busy_r;
    logic              err_r;

    logic              xfer_s;
    logic              csum_clear_s;
    logic              csum_add_s;
    logic [DATA_W-1:0] sum_s;

    assign xfer_s = bus.in_valid & in_ready_r;

    // Checksum control: restart on a frame start, accumulate payload bytes.
    always_comb begin
        csum_clear_s = 1'b0;
        csum_add_s   = 1'b0;
        if (xfer_s) begin
            if (((state_r == IDLE) || (state_r == ERR)) && (bus.in_data == HEADER)) begin
                csum_clear_s = 1'b1;
            end else begin
                csum_clear_s = 1'b0;
            end
            if (state_r == DATA) begin
                csum_add_s = 1'b1;
            end else begin
                csum_add_s = 1'b0;
            end
        end else begin
            csum_clear_s = 1'b0;
            csum_add_s   = 1'b0;
        end
    end

    prog_csum u_csum (
        .clk    (clk),
        .rst    (rst),
        .clear  (csum_clear_s),
        .add_en (csum_add_s),
        .data   (bus.in_data),
        .sum    (sum_s)
    );

    // Frame-parsing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            ptr_r          <= 7'd0;
            cnt_r          <= 7'd0;
            in_ready_r     <= 1'b1;
            inst_address_r <= 7'd0;
            inst_data_r    <= 8'd0;
            inst_we_r      <= 1'b0;
            cpu_run_r      <= 1'b0;
            busy_r         <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; in_ready is only dropped
            // for the one cycle that writes the final data byte.
            inst_we_r  <= 1'b0;
            in_ready_r <= 1'b1;
            if (xfer_s) begin
                case (state_r)
                    IDLE, ERR: begin
                        if (bus.in_data == HEADER) begin
                            state_r   <= ADDR;
                            busy_r    <= 1'b1;
                            cpu_run_r <= 1'b0;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    ADDR: begin
                        ptr_r   <= bus.in_data[ADDR_W-1:0];
                        state_r <= COUNT;
                    end
                    COUNT: begin
                        if (count_ok(bus.in_data)) begin
                            cnt_r   <= bus.in_data[ADDR_W-1:0];
                            state_r <= DATA;
                        end else begin
                            err_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ERR;
                        end
                    end
                    DATA: begin
                        inst_address_r <= ptr_r;
                        inst_data_r    <= bus.in_data;
                        inst_we_r      <= 1'b1;
                        ptr_r          <= ptr_r + 7'd1;
                        cnt_r          <= cnt_r - 7'd1;
                        if (cnt_r == 7'd1) begin
                            in_ready_r <= 1'b0;
                            state_r    <= CSUM;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                    CSUM: begin
                        busy_r <= 1'b0;
                        if (bus.in_data == sum_s) begin
                            err_r     <= 1'b0;
                            cpu_run_r <= 1'b1;
                            state_r   <= IDLE;
                        end else begin
                            err_r     <= 1'b1;
                            cpu_run_r <= 1'b0;
                            state_r   <= ERR;
                        end
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.inst_address = inst_address_r;
    assign bus.inst_data    = inst_data_r;
    assign bus.inst_we      = inst_we_r;
    assign cpu_run          = cpu_run_r;
    assign busy             = busy_r;
    assign err              = err_r;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Expected memory writes are derived
// per frame from the frame format and queued; a monitor pops and compares
// them whenever inst_we pulses. Frame results are checked after each frame.
module tb_prog_loader;

    logic clk;
    logic rst;
    logic cpu_run;
    logic busy;
    logic err;

    prog_loader_if bus();

    prog_loader dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cpu_run (cpu_run),
        .busy    (busy),
        .err     (err)
    );

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
        bit         last;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] frame_data[$];
    int         passed_cnt = 0;
    int         total_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            passed_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.inst_we !== 1'b0) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         bus.inst_address, bus.inst_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("write_addr", 32'(bus.inst_address), 32'(e.a));
                chk("write_data", 32'(bus.inst_data), 32'(e.d));
                chk("in_ready_during_write", 32'(bus.in_ready), 32'(!e.last));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) begin
            total_cnt++;
            $display("FAIL in_ready_timeout: got in_ready %0b for 50 cycles, expected 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic gap(input int max_gap);
        int n;
        n = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (n) @(posedge clk);
        if (n > 0) #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_inst_we"}, 32'(bus.inst_we), 32'd0);
        chk({tag, "_inst_address"}, 32'(bus.inst_address), 32'd0);
        chk({tag, "_inst_data"}, 32'(bus.inst_data), 32'd0);
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Sends a complete frame built from frame_data; the expected writes and
    // result come from the frame format: byte i goes to (addr+i) mod 128 and
    // the frame succeeds exactly when csum equals the byte sum mod 256.
    task automatic run_frame(input logic [7:0] addr, input logic [7:0] csum, input int max_gap);
        int  sum;
        int  n;
        bit  exp_err;
        n   = frame_data.size();
        sum = 0;
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.a    = 7'((int'(addr) + i) % 128);
            e.d    = frame_data[i];
            e.last = (i == n - 1);
            sb.push_back(e);
            sum = (sum + int'(frame_data[i])) % 256;
        end
        exp_err = (sum != int'(csum));

        send_byte(8'hA5);
        chk("busy_after_header", 32'(busy), 32'd1);
        chk("cpu_run_after_header", 32'(cpu_run), 32'd0);
        gap(max_gap);
        send_byte(addr);
        gap(max_gap);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            gap(max_gap);
            send_byte(frame_data[i]);
        end
        gap(max_gap);
        send_byte(csum);
        chk("frame_err", 32'(err), 32'(exp_err));
        chk("frame_cpu_run", 32'(cpu_run), 32'(!exp_err));
        chk("frame_busy", 32'(busy), 32'd0);
        chk("frame_writes_done", 32'(sb.size()), 32'd0);
    endtask

    task automatic bad_count_frame(input logic [7:0] cnt);
        send_byte(8'hA5);
        send_byte(8'h40);
        send_byte(cnt);
        repeat (3) @(posedge clk);
        #1;
        chk("badcount_err", 32'(err), 32'd1);
        chk("badcount_busy", 32'(busy), 32'd0);
        chk("badcount_cpu_run", 32'(cpu_run), 32'd0);
        chk("badcount_no_writes", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // Non-header bytes in IDLE are discarded.
        send_byte(8'h00);
        send_byte(8'h5A);
        send_byte(8'hFF);
        chk("idle_discard_busy", 32'(busy), 32'd0);
        chk("idle_discard_err", 32'(err), 32'd0);

        frame_data = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h10, 8'h66, 0);

        frame_data = '{8'h01, 8'h02, 8'h03};
        run_frame(8'h7E, 8'h06, 0);

        frame_data = '{8'h05, 8'h05};
        run_frame(8'h00, 8'h0B, 0);
        send_byte(8'h00);
        chk("err_discard_err", 32'(err), 32'd1);
        chk("err_discard_busy", 32'(busy), 32'd0);
        frame_data = '{8'h09};
        run_frame(8'h00, 8'h09, 0);

        bad_count_frame(8'h00);
        bad_count_frame(8'h80);

        // HEADER values as address, data and checksum are payload.
        frame_data = '{8'hA5};
        run_frame(8'hA5, 8'hA5, 0);

        // Reset mid-frame: two bytes written, third byte collides with reset.
        begin
            wr_t e;
            e.a = 7'h40; e.d = 8'hD0; e.last = 1'b0; sb.push_back(e);
            e.a = 7'h41; e.d = 8'hD1; e.last = 1'b0; sb.push_back(e);
        end
        send_byte(8'hA5);
        send_byte(8'h40);
        send_byte(8'h04);
        send_byte(8'hD0);
        send_byte(8'hD1);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hD2;
        @(posedge clk);
        #1;
        check_reset_values("midframe_reset");
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midframe_reset_writes", 32'(sb.size()), 32'd0);
        chk("midframe_reset_busy", 32'(busy), 32'd0);

        frame_data = '{8'hAA, 8'h55};
        run_frame(8'h20, 8'hFF, 0);
        frame_data = '{8'hAA, 8'h55};
        run_frame(8'h20, 8'hFF, 5);

        // Randomized frames, some with corrupted checksums, random gaps.
        for (int f = 0; f < 40; f++) begin
            int n;
            int s;
            logic [7:0] cs;
            n = int'($urandom_range(8, 1));
            s = 0;
            frame_data.delete();
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                frame_data.push_back(b);
                s = s + int'(b);
            end
            cs = 8'(s);
            if ($urandom_range(3, 0) == 0) cs = cs + 8'(int'($urandom_range(255, 1)));
            if ($urandom_range(1, 0) == 1) send_byte(8'h3C);
            run_frame(8'($urandom), cs, 5);
        end

        repeat (4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
